store_issue_unit: RTL and testbench
===================================

STORE_ISSUE_UNIT -- requirements
Module: store_issue_unit

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: maximum accepted but unacknowledged stores (range 1-15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive load wins after which a pending store takes priority (range 1-255).
REQ-003 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port sq_valid  in  1  store queue has a released entry at its head.
REQ-006 SHALL have ports sq_addr in 32, sq_be in 4, sq_fn3 in 3, sq_data in 32: head entry, data already lane-aligned.
REQ-007 SHALL have port sq_pop  out  1  one-cycle pop of the store queue head.
REQ-008 SHALL have port load_req  in  1  load pipeline requests the memory port.
REQ-009 SHALL have port load_grant  out  1  load owns the memory port this cycle (combinational).
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32: store request to the memory port.
REQ-011 SHALL have port mem_ack  in  1  memory port accepts the held request this cycle.
REQ-012 SHALL have port mem_wr_done  in  1  one write completion returned (in order, one per cycle at most).
REQ-013 SHALL have ports fence_req in 1 and fence_ack out 1: drain request and drain-complete indication.
REQ-014 SHALL have port stores_idle  out  1  no store held, in flight or pending at the queue head.

Function
REQ-015 SHALL implement states IDLE and HOLD; IDLE->HOLD on capture, HOLD->IDLE on mem_ack.
REQ-016 Capture SHALL occur in IDLE when sq_valid, outstanding < MAX_OUTSTANDING, and (!load_req or starve_cnt == STARVE_LIMIT or fence_req).
REQ-017 On capture, sq_pop SHALL pulse that same cycle and the head fields SHALL be registered into mem_addr/mem_be/mem_wdata with mem_we=1.
REQ-018 mem_req SHALL be 1 exactly in HOLD; request fields SHALL stay stable until mem_ack.
REQ-019 sq_pop SHALL never assert when sq_valid=0 or when in HOLD.
REQ-020 load_grant SHALL equal load_req & IDLE & !capture; the grant has no latency.
REQ-021 starve_cnt (8 bits) SHALL increment, saturating at STARVE_LIMIT, each cycle sq_valid & load_grant; clear on capture or when sq_valid=0.
REQ-022 outstanding (4 bits) SHALL +1 on mem_ack, -1 on mem_wr_done; both in one cycle leaves it unchanged.
REQ-023 mem_wr_done with outstanding==0 SHALL be ignored (count stays 0).
REQ-024 fence_ack SHALL be 1 when fence_req & IDLE & !sq_valid & outstanding==0 & !mem_wr_done-pending, i.e. same cycle as stores_idle.
REQ-025 stores_idle SHALL equal IDLE & !sq_valid & outstanding==0.
REQ-026 While fence_req=1, load_grant SHALL be 0 whenever sq_valid=1 (stores drain before loads).

Reset
REQ-027 On rst: state IDLE, outstanding 0, starve_cnt 0, mem_req 0, mem_we 0, mem_addr/mem_be/mem_wdata 0, sq_pop 0.
REQ-028 Reset mid-HOLD SHALL drop mem_req the next cycle with no pop or ack side effects retained.
REQ-029 stores_idle SHALL read 1 in the first cycle after reset when sq_valid=0.

Structure
REQ-030 The sq entry type and MAX_OUTSTANDING default SHALL live in cva5_types/cva5_config; the module uses discrete ports.
REQ-031 No sub-module; a saturating up/down counter is inline logic.

Verification
REQ-032 sq_valid=1 (addr 0x100, be 0xF, data 0xDEADBEEF), load_req=0, mem_ack cycle 3 -> sq_pop at cycle 0, mem_req cycles 1-3 with stable fields, outstanding=1 at cycle 4.
REQ-033 Four stores acked, no mem_wr_done, fifth sq_valid -> no sq_pop until one mem_wr_done; then capture the next cycle.
REQ-034 sq_valid=1, load_req=1 continuously, STARVE_LIMIT=8 -> load_grant for 8 cycles, store captured cycle 8, load_grant=0 that cycle.
REQ-035 mem_ack and mem_wr_done same cycle with outstanding=2 -> outstanding stays 2.
REQ-036 fence_req with 2 outstanding, sq empty -> fence_ack=0 until second mem_wr_done, then fence_ack=1 and stores_idle=1 the following cycle.
REQ-037 rst asserted in HOLD -> mem_req=0, outstanding=0 after reset, no extra sq_pop.

Source files
------------

// File: rtl/store_issue_unit_pkg.sv
// Shared types for the store issue unit: FSM encoding, store-queue head entry and debug view.
package store_issue_unit_pkg;

   localparam int DEFAULT_MAX_OUTSTANDING = 4;
   localparam int DEFAULT_STARVE_LIMIT    = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } issue_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [2:0]  fn3;
      logic [31:0] data;
   } sq_entry_t;

   typedef struct packed {
      issue_state_t state;
      logic [3:0]   outstanding;
      logic [7:0]   starve_cnt;
      logic [2:0]   fn3;
   } issue_dbg_t;

endpackage

// File: rtl/store_issue_unit.sv
// Arbitrates the memory port between loads and the store queue head, bounds in-flight
// stores, and reports drain completion for fences.
module store_issue_unit
   import store_issue_unit_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sq_valid,
   input  logic [31:0] sq_addr,
   input  logic [3:0]  sq_be,
   input  logic [2:0]  sq_fn3,
   input  logic [31:0] sq_data,
   output logic        sq_pop,
   input  logic        load_req,
   output logic        load_grant,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic        mem_wr_done,
   input  logic        fence_req,
   output logic        fence_ack,
   output logic        stores_idle,
   output issue_dbg_t  dbg
);

   localparam logic [3:0] MAX_OS     = 4'(MAX_OUTSTANDING);
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

   // Handshake: a store request is offered while mem_req=1 and its fields stay frozen;
   // it transfers in the cycle where mem_req=1 and mem_ack=1. sq_pop is a one-cycle
   // consume strobe for the queue head, asserted only when sq_valid=1.
   issue_state_t state_q, state_d;
   sq_entry_t    held_q;
   logic         mem_we_q;
   logic [3:0]   outstanding_q;
   logic [7:0]   starve_q;
   logic         capture;
   logic         room;
   logic         starved;
   logic         os_inc, os_dec;

   assign room    = outstanding_q < MAX_OS;
   assign starved = starve_q == STARVE_LIM;

   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      mem_req    = 1'b0;
      load_grant = 1'b0;
      case (state_q)
         S_IDLE: begin
            capture = !rst && sq_valid && room && (!load_req || starved || fence_req);
            if (capture) state_d = S_HOLD;
            // A fence blocks loads while any store is still waiting at the head.
            load_grant = load_req && !capture && !(fence_req && sq_valid);
         end
         S_HOLD: begin
            mem_req = 1'b1;
            if (mem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sq_pop = capture;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q   <= '0;
         mem_we_q <= 1'b0;
      end else if (capture) begin
         held_q   <= '{addr: sq_addr, be: sq_be, fn3: sq_fn3, data: sq_data};
         mem_we_q <= 1'b1;
      end
   end

   // Completions with nothing in flight are stray and must not wrap the counter.
   assign os_inc = (state_q == S_HOLD) && mem_ack;
   assign os_dec = mem_wr_done && (outstanding_q != 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= 4'd0;
      end else begin
         case ({os_inc, os_dec})
            2'b10:   outstanding_q <= outstanding_q + 4'd1;
            2'b01:   outstanding_q <= outstanding_q - 4'd1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || capture || !sq_valid) starve_q <= 8'd0;
      else if (load_grant && !starved) starve_q <= starve_q + 8'd1;
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = held_q.addr;
   assign mem_be      = held_q.be;
   assign mem_wdata   = held_q.data;
   assign stores_idle = (state_q == S_IDLE) && !sq_valid && (outstanding_q == 4'd0);
   assign fence_ack   = fence_req && stores_idle;

   assign dbg = '{state: state_q, outstanding: outstanding_q, starve_cnt: starve_q,
                  fn3: held_q.fn3};

endmodule

// File: tb/tb_store_issue_unit.sv
// Directed bench for store_issue_unit: scoreboarded store transfers plus cycle-exact checks
// of arbitration, outstanding limit, starvation override, fence drain and reset.
module tb_store_issue_unit;
  import store_issue_unit_pkg::*;

  logic        clk, rst;
  logic        sq_valid;
  logic [31:0] sq_addr;
  logic [3:0]  sq_be;
  logic [2:0]  sq_fn3;
  logic [31:0] sq_data;
  logic        sq_pop;
  logic        load_req, load_grant;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack, mem_wr_done;
  logic        fence_req, fence_ack;
  logic        stores_idle;
  issue_dbg_t  dbg;

  logic [67:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int exp_pops = 0;
  int exp_os   = 0;

  store_issue_unit #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_be(sq_be), .sq_fn3(sq_fn3), .sq_data(sq_data),
    .sq_pop(sq_pop), .load_req(load_req), .load_grant(load_grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_wr_done(mem_wr_done),
    .fence_req(fence_req), .fence_ack(fence_ack), .stores_idle(stores_idle), .dbg(dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // comparison helpers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted memory request must match the oldest expected store
  always @(negedge clk) begin
    if (sq_pop) pop_cnt++;
    if (!rst && mem_req && mem_ack) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%0h expected=none", {mem_addr, mem_be, mem_wdata});
      end
      if (exp_q.size() != 0) chkw("sb_mem_req", {mem_addr, mem_be, mem_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks: all return positioned 1 time unit after a rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sq_valid = 1'b0; sq_addr = '0; sq_be = '0; sq_fn3 = '0; sq_data = '0;
    load_req = 1'b0; mem_ack = 1'b0; mem_wr_done = 1'b0; fence_req = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    exp_q.delete();
    exp_os = 0;
  endtask

  task automatic present(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    sq_valid = 1'b1; sq_addr = a; sq_be = be; sq_fn3 = 3'b010; sq_data = d;
    exp_q.push_back({a, be, d});
  endtask

  // Offer a store, wait (bounded) for its pop, then ack it after hold_cycles.
  task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input int hold_cycles, input bit with_done);
    int t;
    present(a, be, d);
    t = 0;
    @(negedge clk);
    while (!sq_pop && t < 40) begin
      cyc();
      @(negedge clk);
      t++;
    end
    chk1("store_pop_seen", sq_pop, 1'b1);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    repeat (hold_cycles) cyc();
    mem_ack = 1'b1;
    mem_wr_done = with_done;
    @(negedge clk);
    chk1("req_at_ack", mem_req, 1'b1);
    cyc();
    mem_ack = 1'b0;
    mem_wr_done = 1'b0;
    if (!with_done) exp_os++;
  endtask

  task automatic wr_done();
    mem_wr_done = 1'b1;
    cyc();
    mem_wr_done = 1'b0;
    if (exp_os > 0) exp_os--;
  endtask

  task automatic chk_os(input string tag);
    @(negedge clk);
    chk4(tag, dbg.outstanding, 4'(exp_os));
    cyc();
  endtask

  initial begin
    do_reset();

    // reset state, first cycle after reset
    @(negedge clk);
    chk1("rst_stores_idle", stores_idle, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_sq_pop", sq_pop, 1'b0);
    chk1("rst_state", dbg.state, S_IDLE);
    chk4("rst_outstanding", dbg.outstanding, 4'd0);
    chkw("rst_fields", {mem_addr, mem_be, mem_wdata}, 68'h0);
    cyc();

    // single store, ack in cycle 3
    present(32'h100, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk1("a_pop_c0", sq_pop, 1'b1);
    chk1("a_req_c0", mem_req, 1'b0);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk1("a_req_hold", mem_req, 1'b1);
      chk1("a_we_hold", mem_we, 1'b1);
      chk1("a_nopop_hold", sq_pop, 1'b0);
      chkw("a_fields_hold", {mem_addr, mem_be, mem_wdata}, {32'h100, 4'hF, 32'hDEADBEEF});
      cyc();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk1("a_req_c3", mem_req, 1'b1);
    cyc();
    mem_ack = 1'b0;
    exp_os++;
    @(negedge clk);
    chk1("a_req_c4", mem_req, 1'b0);
    chk4("a_os_c4", dbg.outstanding, 4'd1);
    chk1("a_not_idle", stores_idle, 1'b0);
    cyc();
    wr_done();
    chk_os("a_os_drained");

    // outstanding limit: four in flight block the fifth until one completes
    for (int i = 0; i < 4; i++)
      do_store($urandom, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2), 1'b0);
    chk_os("b_os_full");
    present($urandom, 4'h3, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("b_blocked", sq_pop, 1'b0);
      cyc();
    end
    mem_wr_done = 1'b1;
    @(negedge clk);
    chk1("b_blocked_on_done", sq_pop, 1'b0);
    cyc();
    mem_wr_done = 1'b0;
    exp_os--;
    @(negedge clk);
    chk1("b_pop_after_done", sq_pop, 1'b1);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    exp_os++;
    chk_os("b_os_refull");
    repeat (4) wr_done();
    chk_os("b_os_drained");

    // ack and completion in the same cycle
    do_store($urandom, 4'hF, $urandom, 0, 1'b0);
    do_store($urandom, 4'hC, $urandom, 1, 1'b0);
    chk_os("c_os_two");
    do_store($urandom, 4'h1, $urandom, 1, 1'b1);
    chk_os("c_os_stays_two");
    repeat (2) wr_done();
    chk_os("c_os_drained");

    // stray completion with nothing outstanding
    wr_done();
    chk_os("c_stray_done");

    // load starvation override
    load_req = 1'b1;
    present(32'h2000, 4'h6, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("d_load_grant", load_grant, 1'b1);
      chk1("d_no_pop", sq_pop, 1'b0);
      cyc();
    end
    @(negedge clk);
    chk1("d_pop_starved", sq_pop, 1'b1);
    chk1("d_grant_off", load_grant, 1'b0);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    @(negedge clk);
    chk1("d_grant_in_hold", load_grant, 1'b0);
    chk4("d_starve_cleared", dbg.starve_cnt[3:0], 4'd0);
    cyc();
    mem_ack = 1'b1;
    load_req = 1'b0;
    cyc();
    mem_ack = 1'b0;
    exp_os++;
    wr_done();
    chk_os("d_os_drained");

    // fence: wait for completions, and stores beat loads while fencing
    do_store($urandom, 4'hF, $urandom, 0, 1'b0);
    do_store($urandom, 4'hF, $urandom, 0, 1'b0);
    fence_req = 1'b1;
    @(negedge clk);
    chk1("e_fence_wait", fence_ack, 1'b0);
    chk1("e_idle_wait", stores_idle, 1'b0);
    cyc();
    mem_wr_done = 1'b1;
    @(negedge clk);
    chk1("e_fence_wait1", fence_ack, 1'b0);
    cyc();
    @(negedge clk);
    chk1("e_fence_wait2", fence_ack, 1'b0);
    cyc();
    mem_wr_done = 1'b0;
    exp_os = 0;
    @(negedge clk);
    chk1("e_fence_ack", fence_ack, 1'b1);
    chk1("e_stores_idle", stores_idle, 1'b1);
    cyc();
    load_req = 1'b1;
    present(32'h40, 4'h8, 32'hCAFE_0001);
    @(negedge clk);
    chk1("e_fence_pop", sq_pop, 1'b1);
    chk1("e_fence_no_grant", load_grant, 1'b0);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    load_req = 1'b0;
    fence_req = 1'b0;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    exp_os++;
    wr_done();
    chk_os("e_os_drained");

    // reset while holding a request
    present(32'h500, 4'hF, 32'h0BAD_F00D);
    @(negedge clk);
    chk1("f_pop", sq_pop, 1'b1);
    exp_pops++;
    cyc();
    sq_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk1("f_nopop_in_rst", sq_pop, 1'b0);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    exp_os = 0;
    @(negedge clk);
    chk1("f_req_dropped", mem_req, 1'b0);
    chk4("f_os_zero", dbg.outstanding, 4'd0);
    chk1("f_stores_idle", stores_idle, 1'b1);
    chk1("f_no_extra_pop", sq_pop, 1'b0);
    cyc();

    // end-of-run bookkeeping
    chkw("pop_total", 68'(pop_cnt), 68'(exp_pops));
    chkw("sb_empty", 68'(exp_q.size()), 68'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
